vec3_result_collector: RTL and testbench
========================================

// Module: vec3_result_collector
// PURPOSE
//  Receive end of the three per-lane float_add_sub result streams (m_axis_result_tvalid/tdata).
//  The FP IP has no back-pressure and the lanes may return results in different cycles.
//  This block buffers each lane in a FIFO, re-aligns the lanes into whole vec3_f16 vectors
//  and presents them on a ready/valid port. An issue-credit output stops the operand producer
//  from overrunning the buffers.
// PARAMETERS
//  DEPTH  8   entries per lane FIFO and max outstanding vectors; power of two, >=2
//  WIDTH  16  lane data width (f16)
// PORTS
//  clk         in   1          clock; all logic rising-edge
//  rst         in   1          asynchronous, active-high reset
//  issue       in   1          producer launches one vector into the three float_add_sub lanes
//  issue_ok    out  1          credit available: a launch this cycle is accepted
//  lane_tvalid in   3          per-lane m_axis_result_tvalid, bit i = lane i
//  lane_tdata  in   3*WIDTH    per-lane m_axis_result_tdata, lane i at [i*WIDTH +: WIDTH]
//  m_valid     out  1          aligned vector available
//  m_ready     in   1          downstream accepts vector
//  m_data      out  3*WIDTH    vec3_f16, lane i at [i*WIDTH +: WIDTH]
//  overflow    out  1          sticky error: dropped lane result or refused issue
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all FIFO pointers 0; m_valid=0; overflow=0; outstanding=0; issue_ok=1.
//   - m_data is don't-care while m_valid=0.
//  Lane FIFOs:
//   - Pointers are clog2(DEPTH)+1 bits and wrap naturally.
//   - full = MSBs differ and LSBs equal; empty = pointers equal.
//   - lane_tvalid[i]=1 pushes lane_tdata lane i at the tail.
//   - A push to a full lane is dropped and sets overflow, unless a pop occurs the same cycle.
//     In that case the push is accepted.
//  Output:
//   - m_valid = all three lanes non-empty (combinational from registered pointers).
//   - m_data = the three FIFO heads (show-ahead).
//   - Pop = m_valid & m_ready, which pops all three lanes together.
//   - m_data and m_valid stay stable while m_valid & !m_ready, because pushes only touch the tails.
//  Latency:
//   - The last-arriving lane result at edge N gives m_valid=1 after edge N.
//   - That is 1 cycle at minimum, and no bubble between back-to-back vectors.
//  Credit:
//   - outstanding counts 0..DEPTH.
//   - issue & issue_ok: +1. Pop: -1. Both in the same cycle: unchanged.
//   - issue_ok = (outstanding < DEPTH).
//   - issue while !issue_ok is not counted and sets overflow.
//   - Honouring issue_ok guarantees that no lane FIFO can overflow.
//  overflow:
//   - Cleared only by rst.
//   - Reset mid-operation discards all buffered and in-flight data.
//   - Results arriving after reset are pushed normally; the producer must flush the FP IP itself.
// CONFIGURATION
//  VEC3_COLLECT_NAN_FLAG_EN:
//   - Defined: adds output port m_nan (1 bit), valid with m_valid.
//     m_nan=1 iff any head lane is f16 NaN (exp==5'h1F and mantissa!=0). m_nan=0 in reset.
//   - Undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  1. Reset:
//     rst pulse -> m_valid=0, issue_ok=1, overflow=0 during and after reset.
//  2. Aligned lanes:
//     lane_tvalid=3'b111 with data 3C00/4000/4200, m_ready=1
//     -> next cycle m_valid=1, m_data={4200,4000,3C00}, then popped.
//  3. Skewed lanes:
//     lane0 at cycle 0, lane1 at cycle 2, lane2 at cycle 5
//     -> m_valid first 1 in cycle 6 with the correct triple.
//     Hold m_ready=0 for 3 cycles -> m_data stable.
//  4. Credit:
//     issue 8 times with no pops -> issue_ok=0. A 9th issue sets overflow.
//     One pop -> issue_ok=1 the next cycle.
//  5. Full lane:
//     fill lane0 with 8 results, m_ready=0 -> 9th push dropped, overflow=1.
//     Repeat with a pop in the same cycle -> push accepted, overflow stays 0.
//  6. NaN (macro defined):
//     lane1=7E00, others 3C00 -> m_nan=1. All lanes 7C00 (inf) -> m_nan=0.

Source files
------------

// File: rtl/vec3_result_collector.sv
// Re-aligns three independently timed float_add_sub lane results into whole vec3_f16 vectors.
// Optional m_nan output is built only when VEC3_COLLECT_NAN_FLAG_EN is defined.
module vec3_result_collector #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue,
  output logic               issue_ok,
  input  logic [2:0]         lane_tvalid,
  input  logic [3*WIDTH-1:0] lane_tdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [3*WIDTH-1:0] m_data,
`ifdef VEC3_COLLECT_NAN_FLAG_EN
  output logic               m_nan,
`endif
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [2:0]    lane_empty;
  logic [2:0]    lane_drop;
  logic          pop;
  logic          issue_acc;
  logic          issue_bad;
  logic [CW-1:0] outstanding;

  assign m_valid   = ~|lane_empty;
  assign pop       = m_valid & m_ready;
  assign issue_ok  = (outstanding < DEPTH_C);
  assign issue_acc = issue & issue_ok;
  assign issue_bad = issue & ~issue_ok;

  for (genvar i = 0; i < 3; i++) begin : g_lane
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             push;

    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign lane_empty[i] = (wr_ptr == rd_ptr);
    // A full lane may still take a result when the head leaves in the same cycle.
    assign push          = lane_tvalid[i] & (~full | pop);
    assign lane_drop[i]  = lane_tvalid[i] & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= lane_tdata[i*WIDTH +: WIDTH];
    end

    assign m_data[i*WIDTH +: WIDTH] = mem[rd_ptr[AW-1:0]];
  end

  // Pops of results that were never issued (e.g. stale IP output after reset) must not wrap the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (issue_acc && !pop) begin
      outstanding <= outstanding + CW'(1);
    end else if (pop && !issue_acc && outstanding != '0) begin
      outstanding <= outstanding - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if ((|lane_drop) || issue_bad) begin
      overflow <= 1'b1;
    end
  end

`ifdef VEC3_COLLECT_NAN_FLAG_EN
  logic [2:0] lane_nan;

  for (genvar j = 0; j < 3; j++) begin : g_nan
    logic [WIDTH-1:0] head;
    assign head        = m_data[j*WIDTH +: WIDTH];
    assign lane_nan[j] = (&head[14:10]) & (|head[9:0]);
  end

  assign m_nan = m_valid & (|lane_nan);
`endif

endmodule

// File: tb/tb_vec3_result_collector.sv
// Directed scoreboard bench for vec3_result_collector; covers reset, alignment, skew, credit,
// full-lane handling and, with VEC3_COLLECT_NAN_FLAG_EN defined, the NaN flag.
module tb_vec3_result_collector;

  logic        clk;
  logic        rst;
  logic        issue;
  logic        issue_ok;
  logic [2:0]  lane_tvalid;
  logic [47:0] lane_tdata;
  logic        m_valid;
  logic        m_ready;
  logic [47:0] m_data;
  logic        overflow;
`ifdef VEC3_COLLECT_NAN_FLAG_EN
  logic        m_nan;
`endif

  int errors = 0;
  int checks = 0;
  logic [47:0] sb [$];
  logic [47:0] exp_vec;

  vec3_result_collector #(.DEPTH(8), .WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue),
    .issue_ok    (issue_ok),
    .lane_tvalid (lane_tvalid),
    .lane_tdata  (lane_tdata),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
`ifdef VEC3_COLLECT_NAN_FLAG_EN
    .m_nan       (m_nan),
`endif
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] tv, input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] d2, input logic iss, input logic rdy);
    lane_tvalid = tv;
    lane_tdata  = {d2, d1, d0};
    issue       = iss;
    m_ready     = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectPop(input string tag);
    checkOutput({tag, "_valid"}, {47'd0, m_valid}, 48'd1);
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 48'd1, 48'd0);
    end else begin
      exp_vec = sb.pop_front();
      checkOutput({tag, "_data"}, m_data, exp_vec);
    end
  endtask

  task automatic doReset();
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    step();
    checkOutput("rst_m_valid",  {47'd0, m_valid},  48'd0);
    checkOutput("rst_issue_ok", {47'd0, issue_ok}, 48'd1);
    checkOutput("rst_overflow", {47'd0, overflow}, 48'd0);
    step();
    rst = 1'b0;
    step();
    checkOutput("post_rst_m_valid",  {47'd0, m_valid},  48'd0);
    checkOutput("post_rst_issue_ok", {47'd0, issue_ok}, 48'd1);
    checkOutput("post_rst_overflow", {47'd0, overflow}, 48'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("init_m_valid", {47'd0, m_valid}, 48'd0);
    doReset();

    // Aligned lanes, popped immediately
    $display("[TB] aligned lanes");
    applyStimulus(3'b111, 16'h3C00, 16'h4000, 16'h4200, 1'b0, 1'b1);
    sb.push_back({16'h4200, 16'h4000, 16'h3C00});
    checkOutput("aligned_pre_valid", {47'd0, m_valid}, 48'd0);
    step();
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    expectPop("aligned");
    step();
    checkOutput("aligned_after_pop", {47'd0, m_valid}, 48'd0);

    // Skewed lanes: 0 at cycle 0, 1 at cycle 2, 2 at cycle 5
    $display("[TB] skewed lanes");
    sb.push_back({16'hC500, 16'hB800, 16'h3555});
    for (int c = 0; c < 6; c++) begin
      applyStimulus({c == 5, c == 2, c == 0}, 16'h3555, 16'hB800, 16'hC500, 1'b0, 1'b0);
      checkOutput("skew_not_yet_valid", {47'd0, m_valid}, 48'd0);
      step();
    end
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("skew_hold_valid", {47'd0, m_valid}, 48'd1);
      checkOutput("skew_hold_data", m_data, sb[0]);
      step();
    end
    m_ready = 1'b1;
    expectPop("skew");
    step();
    m_ready = 1'b0;
    checkOutput("skew_after_pop", {47'd0, m_valid}, 48'd0);

    // Credit limit and refused issue
    $display("[TB] credit");
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
      checkOutput("credit_ok", {47'd0, issue_ok}, 48'd1);
      step();
    end
    checkOutput("credit_exhausted", {47'd0, issue_ok}, 48'd0);
    checkOutput("credit_no_ovf_yet", {47'd0, overflow}, 48'd0);
    step();
    checkOutput("credit_refused_ovf", {47'd0, overflow}, 48'd1);
    applyStimulus(3'b111, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0);
    sb.push_back({16'h3333, 16'h2222, 16'h1111});
    step();
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("credit_still_zero", {47'd0, issue_ok}, 48'd0);
    expectPop("credit");
    step();
    m_ready = 1'b0;
    checkOutput("credit_returned", {47'd0, issue_ok}, 48'd1);

    // Full lane0, ninth push dropped
    $display("[TB] full lane drop");
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3'b001, 16'h0100 + 16'(k), 16'h0, 16'h0, 1'b0, 1'b0);
      step();
    end
    checkOutput("full_no_ovf", {47'd0, overflow}, 48'd0);
    applyStimulus(3'b001, 16'h0EEE, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("full_drop_ovf", {47'd0, overflow}, 48'd1);
    checkOutput("full_lane_not_valid", {47'd0, m_valid}, 48'd0);

    // Full lane0 with a same-cycle pop: push must be kept
    $display("[TB] full lane with pop");
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus((k == 0) ? 3'b111 : 3'b001, 16'h0100 + 16'(k), 16'hA000, 16'hB000, 1'b0, 1'b0);
      step();
    end
    sb.push_back({16'hB000, 16'hA000, 16'h0100});
    applyStimulus(3'b001, 16'h0200, 16'h0, 16'h0, 1'b0, 1'b1);
    expectPop("full_pop");
    step();
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("full_pop_no_ovf", {47'd0, overflow}, 48'd0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3'b110, 16'h0, 16'hA100 + 16'(k), 16'hB100 + 16'(k), 1'b0, 1'b0);
      sb.push_back({16'hB100 + 16'(k), 16'hA100 + 16'(k), (k == 7) ? 16'h0200 : 16'h0101 + 16'(k)});
      step();
    end
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      expectPop("drain");
      step();
    end
    m_ready = 1'b0;
    checkOutput("drain_empty", {47'd0, m_valid}, 48'd0);
    checkOutput("drain_no_ovf", {47'd0, overflow}, 48'd0);

`ifdef VEC3_COLLECT_NAN_FLAG_EN
    $display("[TB] nan flag");
    doReset();
    checkOutput("nan_reset", {47'd0, m_nan}, 48'd0);
    applyStimulus(3'b111, 16'h3C00, 16'h7E00, 16'h3C00, 1'b0, 1'b0);
    sb.push_back({16'h3C00, 16'h7E00, 16'h3C00});
    step();
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("nan_set", {47'd0, m_nan}, 48'd1);
    expectPop("nan");
    step();
    applyStimulus(3'b111, 16'h7C00, 16'h7C00, 16'h7C00, 1'b0, 1'b0);
    sb.push_back({16'h7C00, 16'h7C00, 16'h7C00});
    step();
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("inf_not_nan", {47'd0, m_nan}, 48'd0);
    expectPop("inf");
    step();
    m_ready = 1'b0;
`endif

    checkOutput("sb_drained", 48'(sb.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
